branch_pc_unit: RTL

//  IF-stage program counter and ID-stage branch/jump resolution for the P8 5-stage MIPS core.

---
 rtl/branch_pc_unit_pkg.sv | 36 +++
 rtl/branch_pc_unit_decide.sv | 39 +++
 rtl/branch_pc_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/branch_pc_unit_pkg.sv
// Shared control-flow encodings and address map for the P8 core front end.
// Also used by the decoder and CP0.
package branch_pc_unit_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BR_BEQ  = 4'd1,
        BR_BNE  = 4'd2,
        BR_BGEZ = 4'd3,
        BR_BLTZ = 4'd4,
        BR_BLEZ = 4'd5,
        BR_BGTZ = 4'd6,
        BR_JIMM = 4'd7,
        BR_JREG = 4'd8
    } br_type_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET  = 32'h0000_3000;
    localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI   = 32'h0000_6FFC;

    function automatic logic fetch_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
    endfunction

    // Encodings 9-15 are reserved and behave as NONE.
    function automatic logic is_ctrl_flow(input logic [3:0] bt);
        return (bt >= 4'd1) && (bt <= 4'd8);
    endfunction

endpackage

// File: rtl/branch_pc_unit_decide.sv
// Branch condition evaluation from the ID-stage comparator vector.
module branch_decide
    import branch_pc_unit_pkg::*;
(
    input  logic [3:0] br_type,
    input  logic [2:0] cmp_rst,
    input  logic       stall,
    output logic       br_taken
);

    logic eq_s;
    logic nonneg_s;
    logic zero_s;

    assign eq_s     = cmp_rst[0];
    assign nonneg_s = cmp_rst[1];
    assign zero_s   = cmp_rst[2];

    // Operands are not valid during a stall, so nothing is taken then.
    always_comb begin
        br_taken = 1'b0;
        if (stall) begin
            br_taken = 1'b0;
        end else begin
            case (br_type)
                BR_BEQ:  br_taken = eq_s;
                BR_BNE:  br_taken = ~eq_s;
                BR_BGEZ: br_taken = nonneg_s;
                BR_BLTZ: br_taken = ~nonneg_s;
                BR_BLEZ: br_taken = ~nonneg_s | zero_s;
                BR_BGTZ: br_taken = nonneg_s & ~zero_s;
                BR_JIMM: br_taken = 1'b1;
                BR_JREG: br_taken = 1'b1;
                default: br_taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// IF-stage PC register, delay-slot flag and redirect FSM with ID-stage
// branch/jump target selection and fetch-address fault detection.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        ExcReq,
    input  logic        EretReq,
    input  logic [31:0] EPC,
    input  logic [3:0]  BrType,
    input  logic [2:0]  CMPrst,
    input  logic [31:0] ID_PC4,
    input  logic [15:0] Imm16,
    input  logic [25:0] Index26,
    input  logic [31:0] RsData,
    output logic [31:0] IF_PC,
    output logic        IF_BD,
    output logic        IF_AdEL,
    output logic        ID_BrTaken,
    output logic [31:0] ID_Link
);

    logic [31:0] pc_q, pc_d;
    logic        bd_q, bd_d;
    pc_state_e   state_q, state_d;
    logic        decide_taken_s;
    logic        br_taken_s;
    logic [31:0] target_s;
    logic [31:0] branch_off_s;

    branch_decide u_decide (
        .br_type  (BrType),
        .cmp_rst  (CMPrst),
        .stall    (Stall),
        .br_taken (decide_taken_s)
    );

    // After a redirect the ID stage holds a flushed bubble; its decode is void.
    assign br_taken_s   = decide_taken_s & (state_q == ST_RUN);
    assign branch_off_s = {{14{Imm16[15]}}, Imm16, 2'b00};

    // Control-flow target for the instruction currently in ID.
    always_comb begin
        target_s = ID_PC4 + branch_off_s;
        case (BrType)
            BR_JIMM: target_s = {ID_PC4[31:28], Index26, 2'b00};
            BR_JREG: target_s = RsData;
            default: target_s = ID_PC4 + branch_off_s;
        endcase
    end

    // Next PC / delay-slot / state selection, highest priority first.
    always_comb begin
        pc_d    = pc_q + 32'd4;
        bd_d    = 1'b0;
        state_d = ST_RUN;
        if (ExcReq) begin
            pc_d    = EXC_ENTRY;
            bd_d    = 1'b0;
            state_d = ST_REDIR;
        end else if (EretReq) begin
            pc_d    = EPC;
            bd_d    = 1'b0;
            state_d = ST_REDIR;
        end else if (Stall) begin
            pc_d    = pc_q;
            bd_d    = bd_q;
            state_d = ST_RUN;
        end else if (state_q == ST_REDIR) begin
            pc_d    = pc_q + 32'd4;
            bd_d    = 1'b0;
            state_d = ST_RUN;
        end else begin
            pc_d    = br_taken_s ? target_s : (pc_q + 32'd4);
            bd_d    = is_ctrl_flow(BrType);
            state_d = ST_RUN;
        end
    end

    // PC, delay-slot flag and redirect state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= PC_RESET;
            bd_q    <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            bd_q    <= bd_d;
            state_q <= state_d;
        end
    end

    assign IF_PC      = pc_q;
    assign IF_BD      = bd_q;
    assign IF_AdEL    = fetch_fault(pc_q);
    assign ID_BrTaken = br_taken_s;
    assign ID_Link    = ID_PC4 + 32'd4;

endmodule
